// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device-side transmitter bank.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GUARD
    } tx_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_GUARD_BITS = 2;

endpackage

// File: rtl/ps2_tx_channel.sv
// One PS/2 transmit port: byte FIFO, clock-line synchroniser and frame FSM.
module ps2_tx_channel
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       phase,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       flush,
    input  logic       clk_in,
    output logic       clk_out,
    output logic       data_out,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow,
    output logic       busy
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] PTR_ONE = 1;
    localparam logic [2:0] LAST_BIT = 3'(PS2_FRAME_BITS - 4);
    localparam logic [1:0] GUARD_END = 2'(PS2_GUARD_BITS - 1);
    localparam logic [1:0] GUARD_ABORT = 2'(PS2_GUARD_BITS);

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wptr;
    logic [FIFO_BITS:0] rptr;
    logic               sync1;
    logic               clk_s;
    tx_state_t          state;
    logic [7:0]         shreg;
    logic [2:0]         bitcnt;
    logic               parity;
    logic [1:0]         gcnt;
    logic               fall_tick;
    logic               rise_tick;
    logic               active;
    logic               pop;
    logic               push;
    logic               abort;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                        (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);
    assign fall_tick  = tick & phase;
    assign rise_tick  = tick & ~phase;
    assign active     = state inside {START, DATA, PARITY, STOP};
    // The byte stays at the head until its stop bit completes, so an abort resends it.
    assign pop        = fall_tick && (state == STOP) && !flush;
    assign push       = wr_en && !fifo_full && !flush;
    assign abort      = rise_tick && !clk_s && (state inside {START, DATA, PARITY});

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[FIFO_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rptr     <= wptr;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop) rptr <= rptr + PTR_ONE;
            if (wr_en && fifo_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            clk_s <= 1'b1;
        end else begin
            sync1 <= clk_in;
            clk_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            clk_out  <= 1'b1;
            data_out <= 1'b1;
            busy     <= 1'b0;
            bitcnt   <= '0;
            gcnt     <= '0;
            parity   <= 1'b0;
        end else if ((flush && active) || abort) begin
            state    <= GUARD;
            gcnt     <= GUARD_ABORT;
            clk_out  <= 1'b1;
            data_out <= 1'b1;
        end else begin
            // Clock low follows phase one tick late, so it tracks the half just entered.
            if (tick) clk_out <= active ? phase : 1'b1;
            if (fall_tick) begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty && clk_s && !flush) begin
                            state    <= START;
                            shreg    <= mem[rptr[FIFO_BITS-1:0]];
                            data_out <= 1'b0;
                            parity   <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        state    <= DATA;
                        data_out <= shreg[0];
                        parity   <= parity ^ shreg[0];
                        shreg    <= shreg >> 1;
                        bitcnt   <= '0;
                    end
                    DATA: begin
                        if (bitcnt == LAST_BIT) begin
                            state    <= PARITY;
                            data_out <= parity;
                        end else begin
                            data_out <= shreg[0];
                            parity   <= parity ^ shreg[0];
                            shreg    <= shreg >> 1;
                            bitcnt   <= bitcnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        data_out <= 1'b1;
                    end
                    STOP: begin
                        state    <= GUARD;
                        gcnt     <= GUARD_END;
                        data_out <= 1'b1;
                    end
                    GUARD: begin
                        if (gcnt == 2'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gcnt <= gcnt - 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_tx_bank.sv
// Bank of PS/2 device-side transmitters sharing one PS/2 clock-enable divider.
module ps2_tx_bank
    import ps2_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int CH_BITS   = 1,
    parameter int FIFO_BITS = 3,
    parameter int CLKDIV    = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_chan,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] flush,
    input  logic [CHANNELS-1:0] ps2_clk_in,
    output logic [CHANNELS-1:0] ps2_clk_out,
    output logic [CHANNELS-1:0] ps2_data_out,
    output logic [CHANNELS-1:0] fifo_full,
    output logic [CHANNELS-1:0] fifo_empty,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] busy
);

    localparam int CNT_W = $clog2(CLKDIV);

    logic [CNT_W-1:0] div_cnt;
    logic             phase;
    logic             tick;

    assign tick = (div_cnt == CNT_W'(CLKDIV - 1));

    // phase 0 is the high half of a bit, phase 1 the low half.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic sel;
        assign sel = wr_en && (int'(wr_chan) == i);

        ps2_tx_channel #(
            .FIFO_BITS(FIFO_BITS)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick      (tick),
            .phase     (phase),
            .wr_en     (sel),
            .wr_data   (wr_data),
            .flush     (flush[i]),
            .clk_in    (ps2_clk_in[i]),
            .clk_out   (ps2_clk_out[i]),
            .data_out  (ps2_data_out[i]),
            .fifo_full (fifo_full[i]),
            .fifo_empty(fifo_empty[i]),
            .overflow  (overflow[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_ps2_tx_bank.sv
// Bench for ps2_tx_bank: cycle-level frame model plus directed scenarios.
module tb_ps2_tx_bank;

    localparam int CH     = 2;
    localparam int CLKDIV = 4;
    localparam int FB     = 3;
    localparam int DEPTH  = 1 << FB;
    localparam int HP     = CLKDIV;
    localparam int BP     = 2 * CLKDIV;
    localparam int M_IDLE = 0, M_FRAME = 1, M_GUARD = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [0:0]    wr_chan = '0;
    logic [7:0]    wr_data = '0;
    logic [CH-1:0] flush = '0;
    logic [CH-1:0] ps2_clk_in = '1;
    logic [CH-1:0] ps2_clk_out, ps2_data_out, fifo_full, fifo_empty, overflow, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_tx_bank #(.CHANNELS(CH), .CH_BITS(1), .FIFO_BITS(FB), .CLKDIV(CLKDIV)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
        .flush(flush), .ps2_clk_in(ps2_clk_in), .ps2_clk_out(ps2_clk_out),
        .ps2_data_out(ps2_data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .busy(busy)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bit i of a byte: start 0, data LSB first, odd parity, stop 1.
    function automatic bit fbit(logic [7:0] b, int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return ~^b;
        return 1'b1;
    endfunction

    // Behavioural model: queue per channel, frame timing from cycle count since reset.
    logic [7:0] mq[CH][$];
    int         mmode[CH];
    int         mc0[CH];
    int         mgend[CH];
    bit         movf[CH];
    bit         mh1[CH], mh2[CH];
    bit         e_clk[CH], e_dat[CH], e_busy[CH], e_empty[CH], e_full[CH], e_ovf[CH];
    int         ck;
    bit         mvalid = 1'b0;

    always @(posedge clk) begin
        bit cs, fall, rise, full, done;
        int o;
        if (!reset_n) begin
            ck = 0;
            mvalid = 1'b1;
            for (int c = 0; c < CH; c++) begin
                mq[c].delete();
                mmode[c] = M_IDLE; movf[c] = 1'b0; mh1[c] = 1'b1; mh2[c] = 1'b1;
                e_clk[c] = 1'b1; e_dat[c] = 1'b1; e_busy[c] = 1'b0;
                e_empty[c] = 1'b1; e_full[c] = 1'b0; e_ovf[c] = 1'b0;
            end
        end else begin
            ck++;
            for (int c = 0; c < CH; c++) begin
                cs = mh2[c];
                mh2[c] = mh1[c];
                mh1[c] = ps2_clk_in[c];
                fall = (ck % BP == 0);
                rise = (ck % BP == HP);
                full = (mq[c].size() == DEPTH);
                done = 1'b0;
                case (mmode[c])
                    M_IDLE: if (fall && !flush[c] && mq[c].size() > 0 && cs) begin
                        mmode[c] = M_FRAME;
                        mc0[c] = ck;
                    end
                    M_FRAME: begin
                        o = (ck - mc0[c]) / HP;
                        if (flush[c]) begin
                            mmode[c] = M_GUARD;
                            mgend[c] = (ck / BP + 1) * BP + 2 * BP;
                        end else if (fall && o == 22) begin
                            done = 1'b1;
                            mmode[c] = M_GUARD;
                            mgend[c] = ck + 2 * BP;
                        end else if (rise && o <= 19 && !cs) begin
                            mmode[c] = M_GUARD;
                            mgend[c] = ck + HP + 2 * BP;
                        end
                    end
                    default: if (ck == mgend[c]) mmode[c] = M_IDLE;
                endcase
                if (flush[c]) begin
                    mq[c].delete();
                    movf[c] = 1'b0;
                end else begin
                    if (done) void'(mq[c].pop_front());
                    if (wr_en && int'(wr_chan) == c) begin
                        if (full) movf[c] = 1'b1;
                        else mq[c].push_back(wr_data);
                    end
                end
                e_busy[c] = (mmode[c] != M_IDLE);
                if (mmode[c] == M_FRAME) begin
                    o = (ck - mc0[c]) / HP;
                    e_clk[c] = (o % 2 == 0);
                    e_dat[c] = fbit(mq[c][0], o / 2);
                end else begin
                    e_clk[c] = 1'b1;
                    e_dat[c] = 1'b1;
                end
                e_empty[c] = (mq[c].size() == 0);
                e_full[c]  = (mq[c].size() == DEPTH);
                e_ovf[c]   = movf[c];
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("ch%0d clk_out", c), ps2_clk_out[c], e_clk[c]);
                check($sformatf("ch%0d data_out", c), ps2_data_out[c], e_dat[c]);
                check($sformatf("ch%0d busy", c), busy[c], e_busy[c]);
                check($sformatf("ch%0d fifo_empty", c), fifo_empty[c], e_empty[c]);
                check($sformatf("ch%0d fifo_full", c), fifo_full[c], e_full[c]);
                check($sformatf("ch%0d overflow", c), overflow[c], e_ovf[c]);
            end
        end
    end

    // Line capture: data value at each clock-low edge, and total low cycles.
    bit capq[CH][$];
    bit prev_clk[CH];
    int lowcnt[CH];

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (prev_clk[c] && !ps2_clk_out[c]) capq[c].push_back(ps2_data_out[c]);
            prev_clk[c] = ps2_clk_out[c];
            if (!ps2_clk_out[c]) lowcnt[c]++;
        end
    end

    function automatic logic [10:0] frame_at(int c, int k);
        logic [10:0] f;
        f = '0;
        for (int i = 0; i < 11; i++)
            if (k * 11 + i < capq[c].size()) f[i] = capq[c][k * 11 + i];
        return f;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(int ch, logic [7:0] d);
        wr_en = 1'b1;
        wr_chan = 1'(ch);
        wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(int ch, int budget, string name);
        int n;
        n = 0;
        while (!(fifo_empty[ch] && !busy[ch]) && n < budget) begin
            step(1);
            n++;
        end
        check({name, " done"}, fifo_empty[ch] && !busy[ch], 1);
    endtask

    task automatic check_bytes(int ch, int nframes, logic [7:0] first, string name);
        logic [10:0] f;
        check({name, " bits"}, capq[ch].size(), nframes * 11);
        for (int k = 0; k < nframes; k++) begin
            f = frame_at(ch, k);
            check($sformatf("%s byte%0d", name, k), f[8:1], first + 8'(k));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] f;
        int n, sz;

        step(3);
        check("reset clk_out", ps2_clk_out, 2'b11);
        check("reset data_out", ps2_data_out, 2'b11);
        check("reset empty", fifo_empty, 2'b11);
        check("reset full/ovf/busy", {fifo_full, overflow, busy}, 6'b0);
        reset_n = 1'b1;
        step(2);

        // Frame encoding of 0x1C on ch0.
        capq[0].delete();
        lowcnt[0] = 0;
        wr(0, 8'h1C);
        wait_done(0, 400, "T1");
        f = frame_at(0, 0);
        check("T1 frame bits", f, 11'h438);
        check("T1 bit count", capq[0].size(), 11);
        check("T1 low cycles", lowcnt[0], 44);

        // Overflow while the host holds the clock low.
        ps2_clk_in[0] = 1'b0;
        step(4);
        for (int i = 0; i < 8; i++) wr(0, 8'(i + 1));
        check("T2 full after 8", fifo_full[0], 1);
        check("T2 no ovf yet", overflow[0], 0);
        wr(0, 8'h09);
        check("T2 ovf after 9", overflow[0], 1);
        check("T2 still idle", busy[0], 0);
        capq[0].delete();
        ps2_clk_in[0] = 1'b1;
        wait_done(0, 3000, "T2");
        check_bytes(0, 8, 8'h01, "T2");

        // Inhibit during data bit 5 of 0xAA on ch1.
        capq[1].delete();
        wr(1, 8'hAA);
        n = 0;
        while (!(capq[1].size() == 6 && ps2_clk_out[1]) && n < 400) begin
            step(1);
            n++;
        end
        check("T3 reached bit5", capq[1].size() == 6 && ps2_clk_out[1], 1);
        ps2_clk_in[1] = 1'b0;
        step(4);
        check("T3 clk released", ps2_clk_out[1], 1);
        check("T3 data released", ps2_data_out[1], 1);
        check("T3 byte kept", fifo_empty[1], 0);
        lowcnt[1] = 0;
        step(8);
        check("T3 no pulses", lowcnt[1], 0);
        check("T3 bits before abort", capq[1].size(), 6);
        step(20);
        capq[1].delete();
        ps2_clk_in[1] = 1'b1;
        wait_done(1, 400, "T3");
        f = frame_at(1, 0);
        check("T3 resent frame", f, 11'h754);
        check("T3 resent count", capq[1].size(), 11);

        // Two channels at once.
        capq[0].delete();
        capq[1].delete();
        wr(0, 8'h12);
        wr(1, 8'h34);
        wait_done(0, 400, "T4 ch0");
        wait_done(1, 400, "T4 ch1");
        f = frame_at(0, 0);
        check("T4 ch0 frame", f, 11'h624);
        f = frame_at(1, 0);
        check("T4 ch1 frame", f, 11'h468);

        // Flush mid-frame with a colliding write.
        capq[0].delete();
        wr(0, 8'h55);
        wr(0, 8'h66);
        wr(0, 8'h77);
        n = 0;
        while (capq[0].size() < 3 && n < 400) begin
            step(1);
            n++;
        end
        check("T5 frame running", busy[0], 1);
        flush = 2'b01;
        wr(0, 8'hEE);
        flush = 2'b00;
        check("T5 empty after flush", fifo_empty[0], 1);
        check("T5 ovf cleared", overflow[0], 0);
        check("T5 lines released", {ps2_clk_out[0], ps2_data_out[0]}, 2'b11);
        n = 0;
        while (busy[0] && n < 100) begin
            step(1);
            n++;
        end
        check("T5 busy fell", busy[0], 0);
        sz = capq[0].size();
        step(300);
        check("T5 no more frames", capq[0].size(), sz);

        // Reset mid-frame.
        capq[1].delete();
        wr(1, 8'h99);
        wr(1, 8'h98);
        n = 0;
        while (capq[1].size() < 2 && n < 400) begin
            step(1);
            n++;
        end
        reset_n = 1'b0;
        step(1);
        check("T6 clk_out", ps2_clk_out, 2'b11);
        check("T6 data_out", ps2_data_out, 2'b11);
        check("T6 empty", fifo_empty, 2'b11);
        check("T6 full/ovf/busy", {fifo_full, overflow, busy}, 6'b0);
        reset_n = 1'b1;
        step(300);
        check("T6 queue lost", {fifo_empty[1], busy[1]}, 2'b10);

        // Write to a full FIFO on the same edge as the stop-bit pop.
        capq[0].delete();
        for (int i = 0; i < 8; i++) wr(0, 8'hA0 + 8'(i));
        check("T7 full", fifo_full[0], 1);
        n = 0;
        while (capq[0].size() < 11 && n < 400) begin
            step(1);
            n++;
        end
        check("T7 in stop bit", capq[0].size(), 11);
        step(2);
        check("T7 full before pop", fifo_full[0], 1);
        wr(0, 8'hEE);
        check("T7 ovf set", overflow[0], 1);
        check("T7 not full", fifo_full[0], 0);
        check("T7 not empty", fifo_empty[0], 0);
        wait_done(0, 3000, "T7");
        check_bytes(0, 8, 8'hA0, "T7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_tx_bank.md
Name: ps2_tx_bank

Overview:
- Multi-channel PS/2 device-side transmitter; each channel emulates one keyboard/mouse port toward the core.
- Generalised successor of the fixed two-port keyboard/mouse emulation: N channels, parametrised FIFO depth, and a single system clock with an internal PS/2 clock-enable divider instead of a core-supplied PS/2 clock.
- Adds host-inhibit detection with abort/retransmit, per-channel flush, full/empty status and sticky overflow.
- Fed by the SPI command decoder, which writes bytes already synchronised to clk.

Parameters:
- CHANNELS, 2: number of PS/2 ports.
- CH_BITS, 1: width of the channel index; must satisfy 2**CH_BITS >= CHANNELS.
- FIFO_BITS, 3: log2 of FIFO depth per channel (8 bytes).
- CLKDIV, 1000: clk cycles per PS/2 half-period; must be >= 4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe, one cycle
- wr_chan  in  CH_BITS  target channel for the write
- wr_data  in  8  byte to queue
- flush  in  CHANNELS  per-channel flush pulse
- ps2_clk_in  in  CHANNELS  sensed PS/2 clock line (async, synchronised inside)
- ps2_clk_out  out  CHANNELS  1 = release line, 0 = drive low
- ps2_data_out  out  CHANNELS  PS/2 data
- fifo_full  out  CHANNELS  FIFO full
- fifo_empty  out  CHANNELS  FIFO empty
- overflow  out  CHANNELS  sticky: a write was dropped
- busy  out  CHANNELS  frame in progress

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - ps2_clk_out=1, ps2_data_out=1, fifo_empty=1, fifo_full=0, overflow=0, busy=0.
  - Pointers, divider and phase all cleared.
- Divider (shared by all channels):
  - Counter runs 0..CLKDIV-1; a one-cycle `tick` fires when it wraps.
  - `phase` toggles on every tick: phase 0 = high half, phase 1 = low half.
  - One bit period is 2 ticks.
- Synchroniser: ps2_clk_in passes through a 2-FF sync per channel → clk_s.
- Per-channel FSM states: IDLE, START, DATA, PARITY, STOP, GUARD.
  - Every state transition happens on a tick where phase goes 1→0.
  - ps2_data_out is updated on that same tick.
  - ps2_clk_out = ~phase while in START..STOP; 1 in IDLE and GUARD.
- IDLE → START:
  - Condition: FIFO non-empty, clk_s=1, and the 1→0 tick.
  - Head byte is latched into the shift register, data_out=0, parity accumulator=1, busy=1.
  - The read pointer is NOT advanced yet.
- DATA:
  - 8 bits, LSB first; 3-bit counter.
  - Parity accumulator toggles on each 1 bit.
- PARITY: drives the accumulator, giving odd parity over data+parity.
- STOP:
  - Drives 1.
  - At the end of the stop bit: pop FIFO (rptr+1), go to GUARD.
- GUARD:
  - Holds lines released for 2 bit periods, then IDLE; busy=0 on entry to IDLE.
  - Frame length is 11 bits = 22 ticks.
- Inhibit:
  - Checked only in START..PARITY, on the tick where phase goes 0→1 (end of the high half, before driving low).
  - If clk_s=0, abort: lines released on that cycle, go to GUARD, no pop.
  - The same byte is retransmitted later.
  - Inhibit during STOP is ignored; the byte counts as sent.
- IDLE never starts while clk_s=0.
- FIFO:
  - Depth 2**FIFO_BITS; pointers are FIFO_BITS+1 wide.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - A write to a full channel is dropped and sets overflow, even if a pop happens in the same cycle.
  - A write and a pop in the same cycle on a non-full FIFO are both performed.
  - wr_chan >= CHANNELS: write ignored.
- Flush:
  - Pointers equalised, overflow cleared.
  - Any active frame is aborted: lines released and FSM set to GUARD.
  - Flush and a write in the same cycle to the same channel: flush wins, write dropped, overflow stays 0.
- Reset mid-frame: lines released the next cycle, queued data lost.

Decomposition:
- Package ps2_pkg:
  - tx_state_t enum.
  - PS2_FRAME_BITS=11.
  - PS2_GUARD_BITS=2.
- Sub-module ps2_tx_channel (FIFO + FSM + sync), instantiated CHANNELS times via generate.
- The divider and the write-demux stay in ps2_tx_bank.

Test Plan:
- Frame encoding: CLKDIV=4, write 0x1C to ch0.
  - data_out per bit = 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop).
  - 11 clock-low pulses of 4 cycles each; fifo_empty returns to 1 at the end of the stop bit.
- Overflow: hold ch0 clk_in=0, write 9 bytes.
  - fifo_full=1 after the 8th write; 9th dropped, overflow=1.
  - Release clk_in: 8 frames emitted in order.
- Inhibit: pull ch1 clk_in low during data bit 5 of 0xAA.
  - Lines released within 1 tick; FIFO still holds 0xAA.
  - After release plus guard, the full 0xAA frame (parity 1) is resent.
- Concurrency: write 0x12 to ch0 and 0x34 to ch1 on consecutive cycles.
  - Both frames run simultaneously, tick-aligned, with independent correct bit patterns.
- Flush/reset: assert flush[0] mid-frame with 3 bytes queued.
  - busy falls after the guard; fifo_empty=1; no further frames.
  - Repeat with reset_n=0 mid-frame: all outputs take their reset values next edge.
- Boundary: write to a full FIFO in the same cycle as the stop-bit pop → write dropped, overflow=1, count = depth-1.
